// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter that lets NCH bus masters share a single-port
// synchronous RAM. One master is granted per clock. The winner drives the
// RAM port, and read data is returned to the requesting master with a
// one-hot valid strobe after RD_LAT clocks.
//
// Optional feature macro: MEM_ARB_PRIO_EN
//   Defined   : channel 0 (CPU) wins whenever it requests and does not move
//               the round-robin pointer. Channels 1..NCH-1 rotate among
//               themselves when channel 0 is idle.
//   Undefined : pure round-robin across all channels.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NCH    = 3,   // master channels (2..8), channel 0 is the CPU
    parameter int AW     = 16,  // address width
    parameter int DW     = 8,   // data width
    parameter int RD_LAT = 1    // RAM read latency in clocks (1..4)
) (
    input  logic              CLOCK_50,
    input  logic              res,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] adr,
    input  logic [NCH*DW-1:0] wdat,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdat,
    output logic [AW-1:0]     mem_adr,
    output logic              mem_we,
    output logic [DW-1:0]     mem_wdat,
    input  logic [DW-1:0]     mem_rdat
);

    localparam int            IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NCH - 1);

    // Round-robin pointer: index of the most recently granted channel.
    logic [IW-1:0]  r_last;

    // Read-tag pipeline, one stage per clock of RAM read latency.
    logic [RD_LAT-1:0] r_tag_vld;
    logic [IW-1:0]     r_tag_chan [RD_LAT];

    // Arbitration result.
    logic              w_any;
    logic [IW-1:0]     w_idx;
    logic [IW-1:0]     w_cand;
    logic              w_rd_issue;

    // Combinational search starting after the last winner, wrapping around.
    always_comb begin
        // NOTE: every signal written here gets a default first so no
        // latch is inferred on paths where no channel is found.
        w_any  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_cand = IW'((int'(r_last) + k) % NCH);
`ifdef MEM_ARB_PRIO_EN
            if (!w_any && req[w_cand] && (w_cand != '0)) begin
`else
            if (!w_any && req[w_cand]) begin
`endif
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
`ifdef MEM_ARB_PRIO_EN
        // The CPU overrides the rotating search whenever it asks.
        if (req[0]) begin
            w_any = 1'b1;
            w_idx = '0;
        end
`endif
        // No grant may escape while the block is held in reset.
        if (!res) begin
            w_any = 1'b0;
            w_idx = '0;
        end
    end

    // One-hot grant decode of the winning index.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt[i] = w_any && (w_idx == IW'(i));
        end
    end

    // RAM port is steered from the winner. Write enable is only live with a grant.
    always_comb begin
        mem_adr    = adr[w_idx*AW +: AW];
        mem_wdat   = wdat[w_idx*DW +: DW];
        mem_we     = w_any && we[w_idx];
        w_rd_issue = w_any && !we[w_idx];
    end

    // Round-robin pointer update on every granted transfer.
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_last <= LAST_RST;
        end else if (w_any) begin
`ifdef MEM_ARB_PRIO_EN
            // CPU grants leave the rotation among the other masters untouched.
            if (w_idx != '0) begin
                r_last <= w_idx;
            end
`else
            r_last <= w_idx;
`endif
        end
    end

    // Tag pipeline: tracks which channel owns each in-flight read.
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            r_tag_vld <= '0;
            // NOTE: the channel tags are reset along with the valid bits.
            // There are only a few of them, and clearing them keeps
            // X values off the rvalid decode after reset.
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_chan[i] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= w_rd_issue;
            r_tag_chan[0] <= w_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_chan[i] <= r_tag_chan[i-1];
            end
        end
    end

    // Retiring stage decodes back to the owning master. Data passes straight through.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NCH; i++) begin
            rvalid[i] = r_tag_vld[RD_LAT-1] && (r_tag_chan[RD_LAT-1] == IW'(i));
        end
        rdat = mem_rdat;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. The stimulus pushes the expected read
// responses into a queue, and a monitor pops and compares them when rvalid
// appears. A second instance with RD_LAT=3 covers deep-pipeline reads and
// reset during an outstanding read.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 16;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              res;
    // Instance with RD_LAT=1
    logic [NCH-1:0]    req, we, gnt, rvalid;
    logic [NCH*AW-1:0] adr;
    logic [NCH*DW-1:0] wdat;
    logic [DW-1:0]     rdat, mem_rdat, mem_wdat;
    logic [AW-1:0]     mem_adr;
    logic              mem_we;
    // Instance with RD_LAT=3
    logic [NCH-1:0]    req3, we3, gnt3, rvalid3;
    logic [NCH*AW-1:0] adr3;
    logic [NCH*DW-1:0] wdat3;
    logic [DW-1:0]     rdat3, mem_rdat3, mem_wdat3;
    logic [AW-1:0]     mem_adr3;
    logic              mem_we3;

    mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
        .CLOCK_50(clk), .res(res), .req(req), .we(we), .adr(adr), .wdat(wdat),
        .gnt(gnt), .rvalid(rvalid), .rdat(rdat), .mem_adr(mem_adr),
        .mem_we(mem_we), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
        .CLOCK_50(clk), .res(res), .req(req3), .we(we3), .adr(adr3), .wdat(wdat3),
        .gnt(gnt3), .rvalid(rvalid3), .rdat(rdat3), .mem_adr(mem_adr3),
        .mem_we(mem_we3), .mem_wdat(mem_wdat3), .mem_rdat(mem_rdat3)
    );

    // RAM models: a shared array, with a 1-clock read port and a 3-clock read port.
    logic [7:0] ram [0:65535];
    logic [7:0] p1, p2, p3;
    always @(posedge clk) begin
        if (mem_we) ram[mem_adr] <= mem_wdat;
        mem_rdat <= ram[mem_adr];
        p1 <= ram[mem_adr3];
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_rdat3 = p3;

    // Edge counter, used to pin each expected read response to its cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        logic [2:0] ch;
        logic [7:0] dat;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: checks each due response, and reports any rvalid nobody expected.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                check("rd_rvalid", rvalid, sb_q[0].ch);
                check("rd_rdat", rdat, sb_q[0].dat);
                void'(sb_q.pop_front());
            end else if (rvalid !== 3'b000) begin
                check("rd_spurious", rvalid, 3'b000);
            end
        end
    end

    // Drive one cycle on the RD_LAT=1 instance and check the combinational outputs.
    // Expected read data is pushed to the scoreboard.
    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] exp_g,
                         input logic exp_we, input logic [15:0] exp_a, input logic [7:0] exp_d,
                         input string nm);
        req = r;
        we  = w;
        #3;
        check({nm, "_gnt"}, gnt, exp_g);
        check({nm, "_we"}, mem_we, exp_we);
        if (exp_g != 3'b000) begin
            check({nm, "_adr"}, mem_adr, exp_a);
            if (exp_we) check({nm, "_wdat"}, mem_wdat, exp_d);
            else        sb_q.push_back('{cyc + 1, exp_g, exp_d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        int c;
        res = 1'b0; req = '0; we = '0; adr = '0; wdat = '0;
        req3 = '0; we3 = '0; adr3 = '0; wdat3 = '0;
        ram[16'h1234] = 8'h5A;
        ram[16'h0010] = 8'h30;
        ram[16'h0011] = 8'h31;
        ram[16'h0012] = 8'h32;

        // Reset held with every channel requesting writes.
        @(posedge clk); #1;
        req = 3'b111; we = 3'b111; req3 = 3'b111;
        #3;
        check("rst_gnt", gnt, 3'b000);
        check("rst_rvalid", rvalid, 3'b000);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_gnt3", gnt3, 3'b000);
        @(posedge clk); #1;
        req3 = 3'b000;

        // Release: the first grant goes to channel 0.
        res = 1'b1;
        adr = {16'h0012, 16'h0011, 16'h0010};
        drive(3'b111, 3'b000, 3'b001, 1'b0, 16'h0010, 8'h30, "rst_first");

        // No request while write flags are high: mem_we stays low.
        drive(3'b000, 3'b111, 3'b000, 1'b0, 16'h0000, 8'h00, "idle");

        // Single read by channel 1.
        adr = {16'h0000, 16'h1234, 16'h0000};
        drive(3'b010, 3'b000, 3'b010, 1'b0, 16'h1234, 8'h5A, "rd1");

        // Channel 2 writes, then channel 0 reads the same location back.
        adr  = {16'h0400, 16'h0000, 16'h0000};
        wdat = {8'hA5, 8'h00, 8'h00};
        drive(3'b100, 3'b100, 3'b100, 1'b1, 16'h0400, 8'hA5, "wr2");
        adr  = {16'h0000, 16'h0000, 16'h0400};
        wdat = '0;
        drive(3'b001, 3'b000, 3'b001, 1'b0, 16'h0400, 8'hA5, "rd0");

        // Channel 2 read leaves last=2, so channel 0 is searched first next.
        adr = {16'h0012, 16'h0011, 16'h0010};
        drive(3'b100, 3'b000, 3'b100, 1'b0, 16'h0012, 8'h32, "pre2");

`ifndef MEM_ARB_PRIO_EN
        // Fairness: all channels request back-to-back reads for 9 cycles.
        for (int i = 0; i < 9; i++) begin
            c = i % 3;
            g = 3'b001 << c;
            drive(3'b111, 3'b000, g, 1'b0, 16'h0010 + 16'(c), 8'h30 + 8'(c), "fair");
        end
`else
        // Priority: CPU on alternate cycles, and channels 1 and 2 rotate in between.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                drive(3'b111, 3'b000, 3'b001, 1'b0, 16'h0010, 8'h30, "prio0");
            end else begin
                c = ((i / 2) % 2 == 0) ? 1 : 2;
                g = 3'b001 << c;
                drive(3'b110, 3'b000, g, 1'b0, 16'h0010 + 16'(c), 8'h30 + 8'(c), "prio_rr");
            end
        end
`endif
        drive(3'b000, 3'b000, 3'b000, 1'b0, 16'h0000, 8'h00, "tail");

        // RD_LAT=3: one read, with rvalid exactly three cycles after the grant edge.
        adr3 = {16'h0000, 16'h1234, 16'h0000};
        req3 = 3'b010;
        #3;
        check("l3_gnt", gnt3, 3'b010);
        check("l3_adr", mem_adr3, 16'h1234);
        @(posedge clk); #1;
        req3 = 3'b000;
        #3; check("l3_c0", rvalid3, 3'b000);
        @(posedge clk); #4; check("l3_c1", rvalid3, 3'b000);
        @(posedge clk); #4;
        check("l3_rvalid", rvalid3, 3'b010);
        check("l3_rdat", rdat3, 8'h5A);
        @(posedge clk); #4; check("l3_after", rvalid3, 3'b000);
        @(posedge clk); #1;

        // RD_LAT=3: reset one cycle after the grant discards the read.
        req3 = 3'b010;
        #3;
        check("mid_gnt", gnt3, 3'b010);
        @(posedge clk); #1;
        req3 = 3'b000;
        res  = 1'b0;
        #3; check("mid_in_rst", rvalid3, 3'b000);
        @(posedge clk); #1;
        res = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3; check("mid_no_rvalid", rvalid3, 3'b000);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
